// File: rtl/mips_fetch_mem_unit_if.sv
// Memory bus between the fetch/mem unit (master) and the memory system (slave).
interface mips_fetch_mem_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds them
    // stable until the slave returns a single-cycle mem_ack; read data is valid only with mem_ack.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_fetch_mem_unit.sv
// Multicycle MIPS front end: PC/IR/MDR and the req/ack memory sequencer that stalls the controller.
// Optional macro MEM_TIMEOUT_EN aborts an access after MEM_TIMEOUT cycles without ack.
module mips_fetch_mem_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 15
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                IorD,
    input  logic                IRWrite,
    input  logic                PCWrite,
    input  logic                PCWriteCond,
    input  logic [1:0]          PCSource,
    input  logic                Zero,
    input  logic [ADDR_W-1:0]   ALUResult,
    input  logic [ADDR_W-1:0]   ALUOut,
    input  logic [DATA_W-1:0]   B,
    mips_fetch_mem_unit_if.master mem,
    output logic                Stall,
    output logic                mem_err,
    output logic [ADDR_W-1:0]   PC,
    output logic [DATA_W-1:0]   IR,
    output logic [DATA_W-1:0]   MDR,
    output logic [5:0]          Op,
    output logic [5:0]          Funct,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              irw_q;
    logic              err_q;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    logic [TO_W-1:0] to_cnt_q;
`endif

    logic              access;
    logic              conflict;
    logic [ADDR_W-1:0] addr_sel;
    logic              misaligned;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_d;

    assign access     = MemRead | MemWrite;
    assign conflict   = MemRead & MemWrite;
    assign addr_sel   = IorD ? ALUOut : pc_q;
    assign misaligned = (addr_sel[1:0] != 2'b00);

    assign Stall   = ((state_q == ST_IDLE) & access) | (state_q == ST_WAIT);
    assign pc_load = ~Stall & (PCWrite | (PCWriteCond & Zero));

    always_comb begin
        pc_d = pc_q;
        case (PCSource)
            2'd0:    pc_d = ALUResult;
            2'd1:    pc_d = ALUOut;
            2'd2:    pc_d = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irw_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            if (pc_load) begin
                pc_q <= pc_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        // A misaligned address never reaches the bus; the error still releases the controller via DONE.
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            req_q    <= 1'b1;
                            we_q     <= MemWrite;
                            addr_q   <= addr_sel;
                            wdata_q  <= B;
                            irw_q    <= IRWrite;
                            err_q    <= conflict;
                            state_q  <= ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= ST_DONE;
                        if (!we_q) begin
                            mdr_q <= mem.mem_rdata;
                            if (irw_q) begin
                                ir_q <= mem.mem_rdata;
                            end
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign mem_err     = err_q;
    assign PC          = pc_q;
    assign IR          = ir_q;
    assign MDR         = mdr_q;
    assign Op          = ir_q[31:26];
    assign Funct       = ir_q[5:0];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_fetch_mem_unit.sv
// Directed bench for mips_fetch_mem_unit: bus transactions scored against an expected queue.
module tb_mips_fetch_mem_unit;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_read, mem_write, ior_d, ir_write;
    logic              pc_write, pc_write_cond, zero;
    logic [1:0]        pc_source;
    logic [ADDR_W-1:0] alu_result, alu_out;
    logic [DATA_W-1:0] b_reg;
    logic              stall, mem_err;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir, mdr;
    logic [5:0]        op, funct;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    // {we, addr, wdata} of each bus request the bench expects the DUT to issue
    logic [64:0] exp_q[$];

    mips_fetch_mem_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

    mips_fetch_mem_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(32'h100), .MEM_TIMEOUT(15)
    ) dut (
        .CLK(clk), .RST_N(rst_n),
        .MemRead(mem_read), .MemWrite(mem_write), .IorD(ior_d), .IRWrite(ir_write),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .PCSource(pc_source), .Zero(zero),
        .ALUResult(alu_result), .ALUOut(alu_out), .B(b_reg),
        .mem(mbus.master),
        .Stall(stall), .mem_err(mem_err), .PC(pc), .IR(ir), .MDR(mdr),
        .Op(op), .Funct(funct), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_q.push_back({we, addr, wdata});
    endtask

    // Memory slave: wait for the request, score it, ack after lat cycles with rdata.
    task automatic do_access(input int lat, input logic [31:0] rdata, input logic exp_err);
        bit seen = 1'b0;
        logic [64:0] exp;
        for (int i = 0; i < 20; i++) begin
            wait_clk();
            if (mbus.mem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_seen", 65'(seen), 65'd1);
        if (seen) begin
            chk("queue_nonempty", 65'(exp_q.size() > 0), 65'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk("bus_txn", {mbus.mem_we, mbus.mem_addr, mbus.mem_wdata}, exp);
            chk("err_at_issue", 65'(mem_err), 65'(exp_err));
            for (int i = 1; i < lat; i++) begin
                wait_clk();
                chk("req_held", 65'({mbus.mem_req, stall}), 65'b11);
            end
            mbus.mem_ack   = 1'b1;
            mbus.mem_rdata = rdata;
            wait_clk();
            mbus.mem_ack   = 1'b0;
            mbus.mem_rdata = '0;
            chk("done_req_stall", 65'({mbus.mem_req, stall, dbg_state}), 65'b0010);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {mem_read, mem_write, ior_d, ir_write, pc_write, pc_write_cond, zero} = '0;
        pc_source = 2'd3; alu_result = '0; alu_out = '0; b_reg = '0;
        mbus.mem_ack = 1'b0; mbus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pc", 65'(pc), 65'h100);
        chk("reset_ir_mdr", {1'b0, ir, mdr}, 65'd0);
        chk("reset_req_stall_err", 65'({mbus.mem_req, stall, mem_err}), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk();

        // Instruction fetch from PC, ack two cycles after request
        mem_read = 1'b1; ior_d = 1'b0; ir_write = 1'b1;
        expect_txn(1'b0, 32'h100, 32'h0);
        #1 chk("fetch_stall_idle", 65'(stall), 65'd1);
        do_access(2, 32'h8C220004, 1'b0);
        mem_read = 1'b0; ir_write = 1'b0;
        chk("fetch_ir", 65'(ir), 65'h8C220004);
        chk("fetch_mdr", 65'(mdr), 65'h8C220004);
        chk("fetch_op_funct", 65'({op, funct}), 65'({6'h23, 6'h04}));
        wait_clk();

        // Store through ALUOut
        mem_write = 1'b1; ior_d = 1'b1; alu_out = 32'h200; b_reg = 32'hDEADBEEF;
        expect_txn(1'b1, 32'h200, 32'hDEADBEEF);
        do_access(1, 32'h12345678, 1'b0);
        mem_write = 1'b0;
        chk("store_mdr_kept", 65'(mdr), 65'h8C220004);
        chk("store_ir_kept", 65'(ir), 65'h8C220004);
        wait_clk();

        // Stray ack while idle must be ignored
        mbus.mem_ack = 1'b1; mbus.mem_rdata = 32'hFFFFFFFF;
        wait_clk();
        mbus.mem_ack = 1'b0; mbus.mem_rdata = '0;
        chk("idle_ack_ignored", {1'b0, ir, mdr}, {1'b0, 32'h8C220004, 32'h8C220004});

        // Misaligned data read
        mem_read = 1'b1; ior_d = 1'b1; alu_out = 32'h202;
        #1 chk("misaligned_stall", 65'(stall), 65'd1);
        wait_clk();
        chk("misaligned_no_req", 65'(mbus.mem_req), 65'd0);
        chk("misaligned_err", 65'({mem_err, dbg_state}), 65'b110);
        mem_read = 1'b0;
        wait_clk();
        chk("misaligned_err_pulse", 65'({mem_err, mbus.mem_req}), 65'd0);

        // Read and write together: issued as a write with an error pulse
        mem_read = 1'b1; mem_write = 1'b1; ior_d = 1'b1; alu_out = 32'h300; b_reg = 32'hCAFEF00D;
        expect_txn(1'b1, 32'h300, 32'hCAFEF00D);
        do_access(3, 32'h55555555, 1'b1);
        mem_read = 1'b0; mem_write = 1'b0;
        chk("both_mdr_kept", 65'(mdr), 65'h8C220004);
        wait_clk();

        // Conditional branch
        pc_write_cond = 1'b1; pc_source = 2'd1; alu_out = 32'h140; zero = 1'b0;
        wait_clk();
        chk("branch_not_taken", 65'(pc), 65'h100);
        zero = 1'b1;
        wait_clk();
        chk("branch_taken", 65'(pc), 65'h140);
        pc_write_cond = 1'b0; zero = 1'b0;

        // Unconditional load back to 0x100, then fetch a jump instruction
        pc_write = 1'b1; pc_source = 2'd0; alu_result = 32'h100;
        wait_clk();
        chk("pc_write_src0", 65'(pc), 65'h100);
        pc_write = 1'b0;
        mem_read = 1'b1; ior_d = 1'b0; ir_write = 1'b1; b_reg = 32'h0;
        expect_txn(1'b0, 32'h100, 32'h0);
        do_access(1, 32'h08000040, 1'b0);
        mem_read = 1'b0; ir_write = 1'b0;
        wait_clk();
        pc_write = 1'b1; pc_source = 2'd2;
        wait_clk();
        chk("jump_low_region", 65'(pc), 65'h100);
        pc_source = 2'd0; alu_result = 32'h70000000;
        wait_clk();
        chk("pc_write_high", 65'(pc), 65'h70000000);
        pc_source = 2'd2;
        wait_clk();
        chk("jump_keeps_top_bits", 65'(pc), 65'h70000100);
        pc_source = 2'd3;
        wait_clk();
        chk("pcsource_hold", 65'(pc), 65'h70000100);

        // PC load is held off while stalled and lands on the DONE edge
        mem_read = 1'b1; ior_d = 1'b0; ir_write = 1'b0; pc_source = 2'd0; alu_result = 32'h104;
        expect_txn(1'b0, 32'h70000100, 32'h0);
        do_access(2, 32'h11111111, 1'b0);
        mem_read = 1'b0;
        chk("pc_frozen_in_stall", 65'(pc), 65'h70000100);
        chk("no_irwrite_ir_kept", 65'(ir), 65'h08000040);
        chk("no_irwrite_mdr", 65'(mdr), 65'h11111111);
        wait_clk();
        chk("pc_load_after_done", 65'(pc), 65'h104);
        pc_write = 1'b0; pc_source = 2'd3;

        // Asynchronous reset during WAIT
        mem_read = 1'b1; ior_d = 1'b0;
        expect_txn(1'b0, 32'h104, 32'h0);
        wait_clk();
        chk("rst_txn_req", 65'(mbus.mem_req), 65'd1);
        chk("rst_txn", {mbus.mem_we, mbus.mem_addr, mbus.mem_wdata}, exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 65'(mbus.mem_req), 65'd0);
        chk("async_rst_pc_state", 65'({pc, dbg_state}), 65'({32'h100, 2'b00}));
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk();

`ifdef MEM_TIMEOUT_EN
        // Timeout: no ack ever arrives
        mem_read = 1'b1; ior_d = 1'b0; ir_write = 1'b1;
        wait_clk();
        chk("to_req_rise", 65'(mbus.mem_req), 65'd1);
        begin
            int cyc = 0;
            for (int i = 1; i <= 40; i++) begin
                wait_clk();
                if (mbus.mem_req !== 1'b1) begin
                    cyc = i;
                    break;
                end
            end
            chk("to_wait_cycles", 65'(cyc), 65'd15);
        end
        chk("to_err", 65'({mem_err, dbg_state}), 65'b110);
        chk("to_ir_kept", 65'(ir), 65'h0);
        mem_read = 1'b0; ir_write = 1'b0;
        wait_clk();
        chk("to_err_pulse", 65'(mem_err), 65'd0);
`endif

        chk("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
